// File: rtl/neuron_sequencer_if.sv
// neuron_sequencer_if: weight-write port, input-element stream, MAC-core
// control/data and result handshake of one neuron sequencer.
// slave  = the sequencer itself
// master = its environment (weight loader, input source, MAC core, consumer)
interface neuron_sequencer_if #(
  parameter int unsigned ADDR_W = 2
);
  logic              w_wr_en;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [7:0]        w_wr_data;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic [7:0]        mac_weight;
  logic [7:0]        mac_in;
  logic              mac_forget;
  logic              mac_oe;
  logic [7:0]        mac_out;
  logic [7:0]        result;
  logic              result_valid;
  logic              result_ready;

  modport master (
    output w_wr_en, w_wr_addr, w_wr_data, in_valid, in_data, mac_out, result_ready,
    input  in_ready, mac_weight, mac_in, mac_forget, mac_oe, result, result_valid
  );

  modport slave (
    input  w_wr_en, w_wr_addr, w_wr_data, in_valid, in_data, mac_out, result_ready,
    output in_ready, mac_weight, mac_in, mac_forget, mac_oe, result, result_valid
  );
endinterface

// File: rtl/neuron_sequencer.sv
// neuron_sequencer: upstream control stage for one 8-bit MAC core.
// Buffers an N_INPUTS-element input vector, holds N_INPUTS weights, streams
// the weight/input pairs into the core, pulses its forget, enables its output
// for one cycle, captures the dot product and offers it with valid/ready.
// Optional build macro NEURON_SEQ_RELU_EN: captured values with bit 7 set are
// replaced by 0 (ReLU on the two's-complement view); otherwise raw unsigned.
module neuron_sequencer #(
  parameter int unsigned N_INPUTS = 4,
  parameter int unsigned ADDR_W   = 2
) (
  input logic               clk,
  input logic               reset,
  neuron_sequencer_if.slave bus
);

  // Storage is sized to the full address space so any index width is legal;
  // entries at or above N_INPUTS are never written and never read.
  localparam int unsigned       DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(N_INPUTS - 1);

  // FLUSH is the one cycle after the last pair in which the core's product
  // register is folded into its accumulator; DRAIN then enables its output.
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STREAM,
    FLUSH,
    DRAIN,
    OUTPUT
  } state_t;

  state_t            state;
  logic [7:0]        w_mem [DEPTH];
  logic [7:0]        x_buf [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] idx_nxt;
  logic              accept;
  logic              w_addr_ok;
  logic [7:0]        capture_val;

  // Handshake qualifiers, next index and the value to capture from the core.
  always_comb begin
    accept    = bus.in_valid && bus.in_ready;
    w_addr_ok = 32'(bus.w_wr_addr) < N_INPUTS;
    idx_nxt   = idx + 1'b1;
`ifdef NEURON_SEQ_RELU_EN
    capture_val = bus.mac_out[7] ? 8'h00 : bus.mac_out;
`else
    capture_val = bus.mac_out;
`endif
  end

  // Sequencer FSM with registered outputs, weight RAM and input buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      idx              <= '0;
      bus.in_ready     <= 1'b1;
      bus.mac_weight   <= '0;
      bus.mac_in       <= '0;
      bus.mac_forget   <= 1'b0;
      bus.mac_oe       <= 1'b0;
      bus.result       <= '0;
      bus.result_valid <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        w_mem[i] <= '0;
        x_buf[i] <= '0;
      end
    end else begin
      bus.mac_forget <= 1'b0;
      bus.mac_oe     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.w_wr_en && w_addr_ok) begin
            w_mem[bus.w_wr_addr] <= bus.w_wr_data;
          end
          if (accept) begin
            x_buf[0] <= bus.in_data;
            if (N_INPUTS == 1) begin
              // A one-element vector is complete on its first accept.
              state          <= STREAM;
              bus.in_ready   <= 1'b0;
              idx            <= '0;
              bus.mac_weight <= w_mem[0];
              bus.mac_in     <= bus.in_data;
            end else begin
              state <= LOAD;
              idx   <= ADDR_W'(1);
            end
          end
        end
        LOAD: begin
          if (accept) begin
            x_buf[idx] <= bus.in_data;
            if (idx == LAST) begin
              state          <= STREAM;
              bus.in_ready   <= 1'b0;
              idx            <= '0;
              bus.mac_weight <= w_mem[0];
              bus.mac_in     <= x_buf[0];
            end else begin
              idx <= idx_nxt;
            end
          end
        end
        STREAM: begin
          // Forget lands one cycle after pair 0 is presented, i.e. while the
          // core folds its first product.
          bus.mac_forget <= (idx == '0);
          if (idx == LAST) begin
            state          <= FLUSH;
            bus.mac_weight <= '0;
            bus.mac_in     <= '0;
          end else begin
            idx            <= idx_nxt;
            bus.mac_weight <= w_mem[idx_nxt];
            bus.mac_in     <= x_buf[idx_nxt];
          end
        end
        FLUSH: begin
          bus.mac_oe <= 1'b1;
          state      <= DRAIN;
        end
        DRAIN: begin
          bus.result       <= capture_val;
          bus.result_valid <= 1'b1;
          state            <= OUTPUT;
        end
        OUTPUT: begin
          if (bus.result_ready) begin
            bus.result_valid <= 1'b0;
            bus.in_ready     <= 1'b1;
            state            <= IDLE;
          end
        end
        default: begin
          state        <= IDLE;
          bus.in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_sequencer.sv
// tb_neuron_sequencer: randomized self-checking bench for neuron_sequencer
// with N_INPUTS=4 and a 3-bit weight address (so out-of-range indices exist).
// A behavioural 8-bit MAC core (product register + accumulator) sits on the
// MAC side; the expected result is the mod-256 dot product of the weights
// and inputs, with ReLU applied when NEURON_SEQ_RELU_EN is defined.
module tb_neuron_sequencer;
  localparam int unsigned N  = 4;
  localparam int unsigned AW = 3;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  neuron_sequencer_if #(.ADDR_W(AW)) bus ();

  neuron_sequencer #(.N_INPUTS(N), .ADDR_W(AW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // MAC core: registers the product, then accumulates it (forget reloads).
  logic [7:0] prod_q = 8'h00;
  logic [7:0] acc_q  = 8'h00;
  always @(posedge clk) begin
    prod_q <= bus.mac_weight * bus.mac_in;
    acc_q  <= bus.mac_forget ? prod_q : acc_q + prod_q;
  end
  // Released bus reads as zero.
  assign bus.mac_out = bus.mac_oe ? acc_q : 8'h00;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [7:0]  w_ref [N];
  logic [7:0]  wv    [N];
  logic [7:0]  xv    [N];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] expected_result();
    int unsigned s;
    s = 0;
    for (int unsigned i = 0; i < N; i++) s += w_ref[i] * xv[i];
    s = s % 256;
`ifdef NEURON_SEQ_RELU_EN
    if (s >= 128) s = 0;
`endif
    return 8'(s);
  endfunction

  // All tasks are entered just after a falling edge and return just after one.
  task automatic write_w(input int unsigned addr, input logic [7:0] data);
    bus.w_wr_en   = 1'b1;
    bus.w_wr_addr = AW'(addr);
    bus.w_wr_data = data;
    @(negedge clk);
    bus.w_wr_en = 1'b0;
    if (addr < N) w_ref[addr] = data;
  endtask

  task automatic program_weights();
    for (int unsigned i = 0; i < N; i++) write_w(i, wv[i]);
  endtask

  task automatic run_vector(input string tag, input int unsigned hold, input int abort_at);
    logic [7:0]  exp_res;
    logic [7:0]  ew;
    logic [7:0]  ex;
    int unsigned waited;
    for (int unsigned e = 0; e < N; e++) begin
      repeat ($urandom_range(0, 2)) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        @(negedge clk);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = xv[e];
      waited = 0;
      while (bus.in_ready !== 1'b1 && waited < 20) begin
        @(negedge clk);
        waited++;
      end
      if (bus.in_ready !== 1'b1) begin
        check({tag, "_in_ready_wait"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    // Now inside t0, the first cycle after the last accept.
    for (int unsigned c = 0; c <= N + 2; c++) begin
      ew = 8'h00;
      ex = 8'h00;
      if (c < N) begin
        ew = w_ref[c];
        ex = xv[c];
      end
      check($sformatf("%s_t0+%0d", tag, c),
            32'({bus.mac_forget, bus.mac_oe, bus.in_ready, bus.result_valid, bus.mac_weight, bus.mac_in}),
            32'({c == 1, c == N + 1, 1'b0, c == N + 2, ew, ex}));
      if (int'(c) == abort_at) begin
        bus.in_valid     = 1'b0;
        bus.result_ready = 1'b0;
        reset = 1'b1;
        #1;
        check({tag, "_abort"},
              32'({bus.in_ready, bus.mac_forget, bus.mac_oe, bus.result_valid, bus.result, bus.mac_weight, bus.mac_in}),
              32'h0800_0000);
        foreach (w_ref[i]) w_ref[i] = 8'h00;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        return;
      end
      if (c < N + 2) begin
        bus.in_valid     = 1'($urandom_range(0, 1));
        bus.in_data      = 8'($urandom);
        bus.result_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
    end
    exp_res = expected_result();
    check({tag, "_result"}, 32'(bus.result), 32'(exp_res));
    bus.result_ready = 1'b0;
    for (int unsigned h = 0; h < hold; h++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_data   = 8'($urandom);
      bus.w_wr_en   = 1'b1;
      bus.w_wr_addr = AW'($urandom_range(0, N - 1));
      bus.w_wr_data = 8'($urandom);
      @(negedge clk);
      check({tag, "_hold"}, 32'({bus.in_ready, bus.result_valid, bus.result}),
            32'({1'b0, 1'b1, exp_res}));
    end
    bus.w_wr_en      = 1'b0;
    bus.in_valid     = 1'b0;
    bus.result_ready = 1'b1;
    @(negedge clk);
    bus.result_ready = 1'b0;
    check({tag, "_release"}, 32'({bus.in_ready, bus.result_valid}), 32'd2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.w_wr_en      = 1'b0;
    bus.w_wr_addr    = '0;
    bus.w_wr_data    = 8'h00;
    bus.in_valid     = 1'b0;
    bus.in_data      = 8'h00;
    bus.result_ready = 1'b0;
    foreach (w_ref[i]) w_ref[i] = 8'h00;
    repeat (2) @(negedge clk);
    check("reset_state",
          32'({bus.in_ready, bus.mac_forget, bus.mac_oe, bus.result_valid, bus.result, bus.mac_weight, bus.mac_in}),
          32'h0800_0000);
    reset = 1'b0;
    @(negedge clk);

    // Basic dot product: 1*5+2*6+3*7+4*8 = 70.
    wv = '{8'd1, 8'd2, 8'd3, 8'd4};
    program_weights();
    xv = '{8'd5, 8'd6, 8'd7, 8'd8};
    run_vector("t1", 0, -1);

    // Mod-256 wrap, then a follow-up vector on a freshly forgotten sum.
    wv = '{8'd16, 8'd16, 8'd16, 8'd16};
    program_weights();
    xv = '{8'd16, 8'd16, 8'd16, 8'd16};
    run_vector("t2a", 1, -1);
    xv = '{8'd1, 8'd1, 8'd1, 8'd1};
    run_vector("t2b", 0, -1);

    // Sign-bit boundary for the optional ReLU.
    wv = '{8'hFF, 8'd0, 8'd0, 8'd0};
    program_weights();
    xv = '{8'd1, 8'd0, 8'd0, 8'd0};
    run_vector("t3a", 0, -1);
    wv = '{8'd1, 8'd0, 8'd0, 8'd0};
    program_weights();
    xv = '{8'h7F, 8'd0, 8'd0, 8'd0};
    run_vector("t3b", 0, -1);
    xv = '{8'h80, 8'd0, 8'd0, 8'd0};
    run_vector("t3c", 0, -1);

    // Long back-pressure with ignored input and weight traffic.
    wv = '{8'd1, 8'd2, 8'd3, 8'd4};
    program_weights();
    xv = '{8'd5, 8'd6, 8'd7, 8'd8};
    run_vector("t4", 10, -1);

    // Reset in the middle of streaming, then a clean rerun.
    run_vector("t5a", 0, 2);
    program_weights();
    run_vector("t5b", 0, -1);

    // Out-of-range weight writes leave the weights untouched.
    write_w(N, 8'd9);
    write_w((1 << AW) - 1, 8'd9);
    run_vector("t6", 0, -1);

    for (int unsigned it = 0; it < 16; it++) begin
      if (it % 3 == 0) begin
        foreach (wv[i]) wv[i] = 8'($urandom);
        program_weights();
        write_w($urandom_range(N, (1 << AW) - 1), 8'($urandom));
      end
      foreach (xv[i]) xv[i] = 8'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        run_vector($sformatf("rnd%0d_abort", it), 0, int'($urandom_range(0, N + 2)));
        program_weights();
      end else begin
        run_vector($sformatf("rnd%0d", it), $urandom_range(0, 3), -1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
